// File: rtl/rr_arb_client.sv
// rr_arb_client: FIFO-buffered requester for one port of a round-robin bus arbiter.
// Define RR_CLIENT_BURST_EN to allow up to BURST beats per grant (otherwise one beat per grant).
module rr_arb_client #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       req,
    input  logic                       grant,
    output logic                       bus_valid,
    output logic [DATA_W-1:0]          bus_data,
    input  logic                       bus_ready
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
        $error("BURST must be in 1..DEPTH");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic              beat, push, last;

    assign beat      = bus_valid & bus_ready;
    // a pop in the same cycle frees the slot, so a push on full is still taken
    assign push      = wr_en & (~full | beat);
    assign full      = level == LW'(DEPTH);
    assign req       = state == ACTIVE;
    assign bus_valid = (state == ACTIVE) & grant & (level != '0);
    assign bus_data  = (level != '0) ? mem[rp] : '0;

`ifdef RR_CLIENT_BURST_EN
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    logic [BW-1:0] beat_cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst)                 beat_cnt <= '0;
        else if (state != ACTIVE) beat_cnt <= '0;
        else if (beat)            beat_cnt <= beat_cnt + 1'b1;
    assign last = (beat_cnt == BW'(BURST - 1)) | ((level == LW'(1)) & ~push);
`else
    assign last = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (level != '0) ? ACTIVE : IDLE;
            ACTIVE:  state_nx = (beat & last) ? RELEASE : ACTIVE;
            RELEASE: state_nx = grant ? RELEASE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            state <= state_nx;
            wp    <= wp + PW'(push);
            rp    <= rp + PW'(beat);
            level <= level + LW'(push) - LW'(beat);
        end

    always_ff @(posedge clk)
        if (push) mem[wp] <= wr_data;
endmodule

// File: tb/tb_rr_arb_client.sv
// tb_rr_arb_client: vector table, corner sequences and randomized run against a queue-based model.
module tb_rr_arb_client;
`ifdef RR_CLIENT_BURST_EN
    localparam int EB = 2;
`else
    localparam int EB = 1;
`endif

    logic       clk = 0, rst = 0, wr_en = 0, grant = 0, bus_ready = 1;
    logic [7:0] wr_data = 0;
    logic       full, req, bus_valid;
    logic [2:0] level;
    logic [7:0] bus_data;
    int         checks = 0, errors = 0;

    rr_arb_client #(.DATA_W(8), .DEPTH(4), .BURST(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
        .req(req), .grant(grant), .bus_valid(bus_valid), .bus_data(bus_data), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       g, rdy, rq, v;
        logic [7:0] data;
        logic [2:0] lvl;
        logic       f;
    } vec_t;
    vec_t tv[$];

    function automatic void add(input logic wr, input logic [7:0] d, input logic g, rdy, rq, v,
                                input logic [7:0] data, input logic [2:0] lvl, input logic f);
        tv.push_back('{wr, d, g, rdy, rq, v, data, lvl, f});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; wr_en = 0; grant = 0; bus_ready = 1; wr_data = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic run_table();
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            wr_en = tv[i].wr; wr_data = tv[i].d; grant = tv[i].g; bus_ready = tv[i].rdy;
            #1;
            chk($sformatf("tv%0d req", i), req, tv[i].rq);
            chk($sformatf("tv%0d valid", i), bus_valid, tv[i].v);
            chk($sformatf("tv%0d data", i), bus_data, tv[i].data);
            chk($sformatf("tv%0d level", i), level, tv[i].lvl);
            chk($sformatf("tv%0d full", i), full, tv[i].f);
        end
    endtask

    task automatic burst_seq();
        logic [7:0] w[4];
        logic       pr;
        int         beats, tenures, low;
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        pr = 0; beats = 0; tenures = 0; low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wr_en = i < 4; wr_data = (i < 4) ? w[i] : 8'h00; grant = pr; bus_ready = 1;
            #1;
            if (req && !pr) begin
                if (tenures > 0) chk("req low gap>=2", low >= 2, 1);
                tenures++;
            end
            low = req ? 0 : low + 1;
            if (bus_valid && bus_ready) begin
                if (beats < 4) chk($sformatf("burst beat%0d", beats), bus_data, w[beats]);
                beats++;
            end
            pr = req;
        end
        chk("burst beat count", beats, 4);
        chk("burst tenures", tenures, 4 / EB);
    endtask

    task automatic reset_seq();
        logic pr;
        pr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = i < 3; wr_data = 8'h70 + 8'(i); grant = pr;
            #1;
            pr = req;
        end
        chk("pre-reset level", level, 3);
        chk("pre-reset valid", bus_valid, 1);
        #2 rst = 0;
        #1;
        chk("async rst req", req, 0);
        chk("async rst valid", bus_valid, 0);
        chk("async rst level", level, 0);
        chk("async rst data", bus_data, 0);
        @(negedge clk);
        rst = 1; wr_en = 0; grant = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-rst idle req%0d", i), req, 0);
        end
    endtask

    task automatic random_run(input int n);
        logic [7:0] q[$];
        logic       m_req, m_rel, beat, pushed, pr;
        int         m_cnt;
        m_req = 0; m_rel = 0; m_cnt = 0; pr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = $urandom_range(0, 2) == 0; wr_data = 8'($urandom);
            grant = pr & ($urandom_range(0, 3) != 0);
            bus_ready = $urandom_range(0, 3) != 0;
            #1;
            chk("rnd req", req, m_req);
            chk("rnd valid", bus_valid, m_req & grant & (q.size() != 0));
            chk("rnd data", bus_data, (q.size() != 0) ? q[0] : 8'h00);
            chk("rnd level", level, q.size());
            chk("rnd full", full, q.size() == 4);
            pr = m_req;
            @(posedge clk);
            beat = m_req && grant && q.size() != 0 && bus_ready;
            pushed = wr_en && (q.size() < 4 || beat);
            if (m_rel) begin
                if (!grant) m_rel = 0;
            end else if (!m_req) begin
                if (q.size() != 0) begin m_req = 1; m_cnt = 0; end
            end else if (beat) begin
                m_cnt++;
                if (m_cnt == EB || (q.size() == 1 && !pushed)) begin m_req = 0; m_rel = 1; end
            end
            if (beat) void'(q.pop_front());
            if (pushed) q.push_back(wr_data);
        end
    endtask

    initial begin
        #1;
        chk("reset req", req, 0);
        chk("reset valid", bus_valid, 0);
        chk("reset level", level, 0);
        chk("reset full", full, 0);
        chk("reset data", bus_data, 0);
        // single word A1
        add(1, 8'hA1, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'hA1, 1, 0);
        add(0, 8'h00, 0, 1, 1, 0, 8'hA1, 1, 0);
        add(0, 8'h00, 1, 1, 1, 1, 8'hA1, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        // backpressure on B5
        add(1, 8'hB5, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'hB5, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0, 8'hB5, 1, 0);
        add(0, 8'h00, 1, 0, 1, 1, 8'hB5, 1, 0);
        add(0, 8'h00, 1, 0, 1, 1, 8'hB5, 1, 0);
        add(0, 8'h00, 1, 0, 1, 1, 8'hB5, 1, 0);
        add(0, 8'h00, 1, 1, 1, 1, 8'hB5, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        // fill, drop, push+pop on full, grant loss and resume
        add(1, 8'h01, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 8'h02, 0, 1, 0, 0, 8'h01, 1, 0);
        add(1, 8'h03, 0, 1, 1, 0, 8'h01, 2, 0);
        add(1, 8'h04, 0, 1, 1, 0, 8'h01, 3, 0);
        add(1, 8'h05, 0, 1, 1, 0, 8'h01, 4, 1);
        add(0, 8'h00, 0, 1, 1, 0, 8'h01, 4, 1);
        add(1, 8'h06, 1, 1, 1, 1, 8'h01, 4, 1);
        add(0, 8'h00, 0, 1, EB > 1, 0, 8'h02, 4, 1);
        add(0, 8'h00, 0, 1, EB > 1, 0, 8'h02, 4, 1);
        add(0, 8'h00, 1, 1, 1, 1, 8'h02, 4, 1);
        rst = 1;
        run_table();
        do_reset();
        burst_seq();
        do_reset();
        reset_seq();
        do_reset();
        random_run(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end
endmodule
